// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack engine:
// opcode encodings and FSM state type.
package rpn_pkg;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_DUP   = 3'd5;
  localparam logic [2:0] OP_SWAP  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/rpn_stack_engine_ram.sv
// Stack storage below TOS: sync write, registered
// read (1-cycle latency). Ports: clk, we/waddr/wdata,
// re/raddr, rdata. No reset on the array.
module rpn_stack_engine_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN stack/ALU engine: TOS in a register, the rest in
// stack RAM. Ports: CLOCK_50, RESET_N, cmd_* handshake,
// tos/depth/empty/full status, done pulse, error flags.
module rpn_stack_engine
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] tos,
  output logic [CW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             done,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             arith_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TWO = CW'(2);
  localparam logic [CW-1:0] DEP_C = CW'(DEPTH);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic             done_q, done_d;
  logic             eo_q, eo_d;
  logic             eu_q, eu_d;
  logic             ao_q, ao_d;

  logic             we, re;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] wdata, nos;
  logic [CW-1:0]    dm1, dm2;
  logic             is_full, is_empty;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  rpn_stack_engine_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk   (CLOCK_50),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (nos)
  );

  assign dm1 = depth_q - ONE;
  assign dm2 = depth_q - TWO;
  assign is_full = (depth_q == DEP_C);
  assign is_empty = (depth_q == ZERO);

  assign sum = {1'b0, nos} + {1'b0, tos_q};
  assign prod = {{WIDTH{1'b0}}, nos}
              * {{WIDTH{1'b0}}, tos_q};

  always_comb begin
    state_d = state_q;
    op_d = op_q;
    tos_d = tos_q;
    depth_d = depth_q;
    done_d = 1'b0;
    eo_d = eo_q;
    eu_d = eu_q;
    ao_d = ao_q;
    we = 1'b0;
    waddr = dm1[AW-1:0];
    wdata = tos_q;
    re = 1'b0;
    raddr = dm2[AW-1:0];
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          done_d = 1'b1;
          unique case (cmd_op)
            OP_PUSH: begin
              if (is_full) begin
                eo_d = 1'b1;
              end else begin
                we = !is_empty;
                tos_d = cmd_data;
                depth_d = depth_q + ONE;
              end
            end
            OP_DUP: begin
              if (is_empty) begin
                eu_d = 1'b1;
              end else if (is_full) begin
                eo_d = 1'b1;
              end else begin
                we = 1'b1;
                depth_d = depth_q + ONE;
              end
            end
            OP_CLEAR: begin
              tos_d = '0;
              depth_d = ZERO;
              eo_d = 1'b0;
              eu_d = 1'b0;
              ao_d = 1'b0;
            end
            OP_POP: begin
              if (is_empty) begin
                eu_d = 1'b1;
              end else if (depth_q == ONE) begin
                tos_d = '0;
                depth_d = ZERO;
              end else begin
                // NOS needed: fetch it, finish in EXEC
                re = 1'b1;
                op_d = cmd_op;
                state_d = S_EXEC;
                done_d = 1'b0;
              end
            end
            default: begin
              // ADD, SUB, MUL, SWAP need two operands
              if (depth_q < TWO) begin
                eu_d = 1'b1;
              end else begin
                re = 1'b1;
                op_d = cmd_op;
                state_d = S_EXEC;
                done_d = 1'b0;
              end
            end
          endcase
        end
      end
      S_EXEC: begin
        done_d = 1'b1;
        state_d = S_IDLE;
        depth_d = dm1;
        unique case (op_q)
          OP_ADD: begin
            tos_d = sum[WIDTH-1:0];
            ao_d = sum[WIDTH];
          end
          OP_SUB: begin
            tos_d = nos - tos_q;
            ao_d = (nos < tos_q);
          end
          OP_MUL: begin
            tos_d = prod[WIDTH-1:0];
            ao_d = |prod[2*WIDTH-1:WIDTH];
          end
          OP_SWAP: begin
            we = 1'b1;
            waddr = dm2[AW-1:0];
            tos_d = nos;
            depth_d = depth_q;
          end
          default: begin
            tos_d = nos;
          end
        endcase
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      op_q <= OP_PUSH;
      tos_q <= '0;
      depth_q <= ZERO;
      done_q <= 1'b0;
      eo_q <= 1'b0;
      eu_q <= 1'b0;
      ao_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      tos_q <= tos_d;
      depth_q <= depth_d;
      done_q <= done_d;
      eo_q <= eo_d;
      eu_q <= eu_d;
      ao_q <= ao_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign tos = tos_q;
  assign depth = depth_q;
  assign empty = is_empty;
  assign full = is_full;
  assign done = done_q;
  assign err_overflow = eo_q;
  assign err_underflow = eu_q;
  assign arith_ovf = ao_q;

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Bench for rpn_stack_engine (WIDTH=8, DEPTH=4):
// vector table, reset-in-EXEC sequence, random vs model.
module tb_rpn_stack_engine;
  import rpn_pkg::*;

  localparam int W = 8;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] tos;
  logic [CW-1:0] depth;
  logic empty, full, done;
  logic err_overflow, err_underflow, arith_ovf;

  int errs = 0;
  int checks = 0;

  int q[$];
  bit m_eo, m_eu, m_ao;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d;
    int tos;
    int dep;
    int lat;
    bit eo;
    bit eu;
    bit ao;
  } vec_t;

  vec_t tbl[$];

  rpn_stack_engine #(
    .WIDTH(W),
    .DEPTH(DP)
  ) dut (
    .CLOCK_50      (clk),
    .RESET_N       (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .tos           (tos),
    .depth         (depth),
    .empty         (empty),
    .full          (full),
    .done          (done),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .arith_ovf     (arith_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [2:0] op,
                      input logic [7:0] d,
                      output int lat,
                      output int rlow);
    int w;
    lat = 0;
    rlow = 0;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("ready_wait", int'(cmd_ready), 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data = $urandom_range(0, 255);
    for (int i = 1; i <= 8; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (!cmd_ready) rlow++;
      @(negedge clk);
    end
  endtask

  task automatic model(input logic [2:0] op,
                       input logic [7:0] d,
                       output int lat);
    int n, a, b, r;
    n = q.size();
    lat = 1;
    case (op)
      OP_PUSH:
        if (n == DP) m_eo = 1;
        else q.push_back(int'(d));
      OP_POP:
        if (n == 0) m_eu = 1;
        else begin
          if (n >= 2) lat = 2;
          void'(q.pop_back());
        end
      OP_ADD, OP_SUB, OP_MUL:
        if (n < 2) m_eu = 1;
        else begin
          lat = 2;
          b = q.pop_back();
          a = q.pop_back();
          if (op == OP_ADD) r = a + b;
          else if (op == OP_SUB) r = a - b;
          else r = a * b;
          if (op == OP_SUB) m_ao = (a < b);
          else m_ao = (r > 255);
          q.push_back(r & 255);
        end
      OP_DUP:
        if (n == 0) m_eu = 1;
        else if (n == DP) m_eo = 1;
        else q.push_back(q[n-1]);
      OP_SWAP:
        if (n < 2) m_eu = 1;
        else begin
          lat = 2;
          b = q.pop_back();
          a = q.pop_back();
          q.push_back(b);
          q.push_back(a);
        end
      default: begin
        q.delete();
        m_eo = 0;
        m_eu = 0;
        m_ao = 0;
      end
    endcase
  endtask

  task automatic add(input logic [2:0] op,
                     input int d, input int t,
                     input int dep, input int lat,
                     input bit eo, input bit eu,
                     input bit ao);
    vec_t v;
    v.op = op;
    v.d = 8'(d);
    v.tos = t;
    v.dep = dep;
    v.lat = lat;
    v.eo = eo;
    v.eu = eu;
    v.ao = ao;
    tbl.push_back(v);
  endtask

  initial begin
    int lat, rl, mlat, et;
    logic [2:0] op;
    logic [7:0] d;

    add(OP_PUSH,  5,   5, 1, 1, 0, 0, 0);
    add(OP_PUSH,  3,   3, 2, 1, 0, 0, 0);
    add(OP_SUB,   0,   2, 1, 2, 0, 0, 0);
    add(OP_CLEAR, 0,   0, 0, 1, 0, 0, 0);
    add(OP_PUSH,  3,   3, 1, 1, 0, 0, 0);
    add(OP_PUSH,  5,   5, 2, 1, 0, 0, 0);
    add(OP_SUB,   0, 254, 1, 2, 0, 0, 1);
    add(OP_PUSH, 16,  16, 2, 1, 0, 0, 1);
    add(OP_PUSH, 16,  16, 3, 1, 0, 0, 1);
    add(OP_MUL,   0,   0, 2, 2, 0, 0, 1);
    add(OP_CLEAR, 0,   0, 0, 1, 0, 0, 0);
    add(OP_PUSH,  1,   1, 1, 1, 0, 0, 0);
    add(OP_PUSH,  2,   2, 2, 1, 0, 0, 0);
    add(OP_PUSH,  3,   3, 3, 1, 0, 0, 0);
    add(OP_PUSH,  4,   4, 4, 1, 0, 0, 0);
    add(OP_PUSH,  9,   4, 4, 1, 1, 0, 0);
    add(OP_POP,   0,   3, 3, 2, 1, 0, 0);
    add(OP_POP,   0,   2, 2, 2, 1, 0, 0);
    add(OP_POP,   0,   1, 1, 2, 1, 0, 0);
    add(OP_POP,   0,   0, 0, 1, 1, 0, 0);
    add(OP_CLEAR, 0,   0, 0, 1, 0, 0, 0);
    add(OP_POP,   0,   0, 0, 1, 0, 1, 0);
    add(OP_PUSH,  7,   7, 1, 1, 0, 1, 0);
    add(OP_ADD,   0,   7, 1, 1, 0, 1, 0);
    add(OP_CLEAR, 0,   0, 0, 1, 0, 0, 0);
    add(OP_PUSH,  1,   1, 1, 1, 0, 0, 0);
    add(OP_PUSH,  2,   2, 2, 1, 0, 0, 0);
    add(OP_SWAP,  0,   1, 2, 2, 0, 0, 0);
    add(OP_POP,   0,   2, 1, 2, 0, 0, 0);
    add(OP_DUP,   0,   2, 2, 1, 0, 0, 0);
    add(OP_DUP,   0,   2, 3, 1, 0, 0, 0);
    add(OP_PUSH, 10,  10, 4, 1, 0, 0, 0);
    add(OP_DUP,   0,  10, 4, 1, 1, 0, 0);

    do_reset();
    chk("rst_tos", int'(tos), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_eo", int'(err_overflow), 0);
    chk("rst_eu", int'(err_underflow), 0);
    chk("rst_ao", int'(arith_ovf), 0);

    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].d, lat, rl);
      chk($sformatf("v%0d_tos", i),
          int'(tos), tbl[i].tos);
      chk($sformatf("v%0d_depth", i),
          int'(depth), tbl[i].dep);
      chk($sformatf("v%0d_lat", i),
          lat, tbl[i].lat);
      chk($sformatf("v%0d_rdylow", i),
          rl, tbl[i].lat - 1);
      chk($sformatf("v%0d_eo", i),
          int'(err_overflow), int'(tbl[i].eo));
      chk($sformatf("v%0d_eu", i),
          int'(err_underflow), int'(tbl[i].eu));
      chk($sformatf("v%0d_ao", i),
          int'(arith_ovf), int'(tbl[i].ao));
      chk($sformatf("v%0d_full", i),
          int'(full), int'(tbl[i].dep == DP));
      chk($sformatf("v%0d_empty", i),
          int'(empty), int'(tbl[i].dep == 0));
    end

    // reset while a MUL sits in EXEC
    do_reset();
    send(OP_PUSH, 8'd1, lat, rl);
    send(OP_PUSH, 8'd2, lat, rl);
    cmd_valid = 1'b1;
    cmd_op = OP_MUL;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_ready", int'(cmd_ready), 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_depth", int'(depth), 0);
    chk("abort_tos", int'(tos), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    @(negedge clk);
    chk("abort_done2", int'(done), 0);

    // valid held high through EXEC: one op only
    send(OP_PUSH, 8'd6, lat, rl);
    send(OP_PUSH, 8'd4, lat, rl);
    cmd_valid = 1'b1;
    cmd_op = OP_ADD;
    @(posedge clk);
    @(negedge clk);
    cmd_op = OP_PUSH;
    cmd_data = 8'd33;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_done", int'(done), 1);
    chk("hold_tos", int'(tos), 10);
    chk("hold_depth", int'(depth), 1);
    @(negedge clk);
    chk("hold_push_tos", int'(tos), 10);

    // random commands against the queue model
    do_reset();
    q.delete();
    m_eo = 0;
    m_eu = 0;
    m_ao = 0;
    for (int n = 0; n < 400; n++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) op = OP_PUSH;
      if (op == OP_CLEAR && $urandom_range(0, 3) != 0)
        op = OP_POP;
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0)
        d = 8'($urandom_range(0, 20));
      model(op, d, mlat);
      send(op, d, lat, rl);
      et = (q.size() > 0) ? q[q.size()-1] : 0;
      chk($sformatf("r%0d_tos", n), int'(tos), et);
      chk($sformatf("r%0d_depth", n),
          int'(depth), q.size());
      chk($sformatf("r%0d_lat", n), lat, mlat);
      chk($sformatf("r%0d_eo", n),
          int'(err_overflow), int'(m_eo));
      chk($sformatf("r%0d_eu", n),
          int'(err_underflow), int'(m_eu));
      chk($sformatf("r%0d_ao", n),
          int'(arith_ovf), int'(m_ao));
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
